// File: rtl/bist_pattern_gen_if.sv
// Pattern handshake between the BIST source and the CUT/capture stage.
// pat_valid/pat_ready accept; pat_out is the vector driven into the CUT.
interface bist_pattern_gen_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] pat_out;
  logic             pat_valid;
  logic             pat_ready;

  modport master (
    output pat_out,
    output pat_valid,
    input  pat_ready
  );

  modport slave (
    input  pat_out,
    input  pat_valid,
    output pat_ready
  );
endinterface

// File: rtl/bist_pattern_gen.sv
// LFSR test pattern source with pattern count and valid/ready handoff.
// Define BIST_ALLZERO_EN to append the all-zero vector to every run.
module bist_pattern_gen #(
  parameter int               WIDTH   = 2,
  parameter logic [WIDTH-1:0] TAPS    = 2'b11,
  parameter int               NUM_PAT = 3,
  parameter int               CW      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_load,
  bist_pattern_gen_if.master pat,
  output logic [CW-1:0]    pat_count,
  output logic             busy,
  output logic             done
);

`ifdef BIST_ALLZERO_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t           r_state;
  state_t           w_nxt_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] w_nxt_lfsr;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_nxt_cnt;
  logic [CW-1:0]    w_cnt_inc;
  logic [WIDTH-1:0] w_lfsr_step;
  logic [WIDTH-1:0] w_seed_ok;

  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_lfsr_step = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  assign w_seed_ok   = (seed == '0) ? WIDTH'(1) : seed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lfsr  <= WIDTH'(1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_lfsr  <= w_nxt_lfsr;
      r_cnt   <= w_nxt_cnt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_lfsr  = r_lfsr;
    w_nxt_cnt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (seed_load) w_nxt_lfsr = w_seed_ok;
        if (start) begin
          w_nxt_state = RUN;
          w_nxt_cnt   = '0;
        end
      end
      RUN: begin
        if (pat.pat_ready) begin
          w_nxt_lfsr = w_lfsr_step;
          w_nxt_cnt  = w_cnt_inc;
          if (w_cnt_inc == CW'(NUM_PAT)) begin
`ifdef BIST_ALLZERO_EN
            w_nxt_state = ZERO;
`else
            w_nxt_state = DONE;
`endif
          end
        end
      end
`ifdef BIST_ALLZERO_EN
      ZERO: begin
        if (pat.pat_ready) begin
          w_nxt_cnt   = w_cnt_inc;
          w_nxt_state = DONE;
        end
      end
`endif
      DONE: w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // Outputs decode from state only; pat_ready never reaches pat_valid.
  always_comb begin
    pat.pat_valid = 1'b0;
    pat.pat_out   = r_lfsr;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (r_state)
      RUN: begin
        pat.pat_valid = 1'b1;
        busy          = 1'b1;
      end
`ifdef BIST_ALLZERO_EN
      ZERO: begin
        pat.pat_valid = 1'b1;
        pat.pat_out   = '0;
        busy          = 1'b1;
      end
`endif
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign pat_count = r_cnt;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Directed bench for bist_pattern_gen at default parameters.
// Checks reset, sequence, backpressure, ignored controls and mid-run reset.
module tb_bist_pattern_gen;

  localparam int W  = 2;
  localparam int CW = 16;
`ifdef BIST_ALLZERO_EN
  localparam int FINAL_CNT = 4;
`else
  localparam int FINAL_CNT = 3;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  seed;
  logic          seed_load;
  logic [CW-1:0] pat_count;
  logic          busy;
  logic          done;

  int total;
  int bad;

  bist_pattern_gen_if #(.WIDTH(W)) u_if ();

  bist_pattern_gen u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .seed_load (seed_load),
    .pat       (u_if),
    .pat_count (pat_count),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pat(input string tag,
                         input logic [W-1:0] p,
                         input int c);
    chk({tag, "_out"}, 32'(u_if.pat_out), 32'(p));
    chk({tag, "_vld"}, 32'(u_if.pat_valid), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_cnt"}, 32'(pat_count), 32'(c));
  endtask

  // Called with pattern 10 showing, cnt=2 and pat_ready=1.
  task automatic fin_run(input string tag);
    tick();
`ifdef BIST_ALLZERO_EN
    chk_pat({tag, "_zero"}, 2'b00, 3);
    tick();
`endif
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_dvld"}, 32'(u_if.pat_valid), 32'd0);
    chk({tag, "_dbusy"}, 32'(busy), 32'd0);
    chk({tag, "_dcnt"}, 32'(pat_count), 32'(FINAL_CNT));
    tick();
    chk({tag, "_done2"}, 32'(done), 32'd0);
    chk({tag, "_busy2"}, 32'(busy), 32'd0);
    chk({tag, "_cnt2"}, 32'(pat_count), 32'(FINAL_CNT));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    start = 1'b0;
    seed = '0;
    seed_load = 1'b0;
    u_if.pat_ready = 1'b0;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_out", 32'(u_if.pat_out), 32'd1);
    chk("rst_vld", 32'(u_if.pat_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(pat_count), 32'd0);

    // Full run from seed 01
    seed = 2'b01;
    seed_load = 1'b1;
    start = 1'b1;
    u_if.pat_ready = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    chk_pat("run_p0", 2'b01, 0);
    tick();
    chk_pat("run_p1", 2'b11, 1);
    tick();
    chk_pat("run_p2", 2'b10, 2);
    fin_run("run");

    // Backpressure; lfsr continues from 01
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_pat("bp_p0", 2'b01, 0);
    tick();
    u_if.pat_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_pat($sformatf("bp_stall%0d", i), 2'b11, 1);
      tick();
    end
    chk_pat("bp_stall4", 2'b11, 1);
    u_if.pat_ready = 1'b1;
    tick();
    chk_pat("bp_p2", 2'b10, 2);
    fin_run("bp");

    // Zero seed sanitised, controls ignored mid-run
    seed = 2'b00;
    seed_load = 1'b1;
    start = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    chk_pat("zs_p0", 2'b01, 0);
    tick();
    chk_pat("zs_p1", 2'b11, 1);
    seed = 2'b10;
    seed_load = 1'b1;
    start = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    chk_pat("ign_p2", 2'b10, 2);
    fin_run("ign");

    // Reset in the middle of a run
    seed = 2'b01;
    seed_load = 1'b1;
    start = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    tick();
    tick();
    chk_pat("mr_p2", 2'b10, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_vld", 32'(u_if.pat_valid), 32'd0);
    chk("mr_cnt", 32'(pat_count), 32'd0);
    chk("mr_out", 32'(u_if.pat_out), 32'd1);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    tick();
    chk("mr_done2", 32'(done), 32'd0);
    chk("mr_vld2", 32'(u_if.pat_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bist_pattern_gen.md
Name: bist_pattern_gen

Overview:
- On-chip test pattern source that sits directly upstream of a combinational circuit under test (CUT), e.g. the 2-input comparator gate.
- Generates pseudo-random input vectors from a Fibonacci LFSR, counts them, and hands each one to the CUT/capture stage over a valid/ready handshake.
- Replaces the simulator-driven pattern file for in-hardware fault grading; the downstream stage samples the CUT response on every accepted pattern.

Parameters:
- WIDTH, 2, pattern width; equals the CUT input count (minimum 2).
- TAPS, 2'b11, LFSR feedback mask, WIDTH bits; bit i set means lfsr[i] feeds the XOR. Must describe a maximal-length polynomial.
- NUM_PAT, 3, number of LFSR patterns per run (minimum 1, maximum 2**CW-1).
- CW, 16, pattern counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; honoured only in IDLE.
- seed  input  WIDTH  LFSR seed value.
- seed_load  input  1  load seed into LFSR; honoured only in IDLE.
- pat_out  output  WIDTH  current pattern to the CUT.
- pat_valid  output  1  pat_out holds a valid pattern.
- pat_ready  input  1  downstream has accepted pat_out this cycle.
- pat_count  output  CW  patterns accepted in the current or last run.
- busy  output  1  high in RUN (and ZERO when enabled).
- done  output  1  single-cycle pulse at end of run.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, lfsr=1 (pat_out=...01), pat_valid=0, busy=0, done=0, pat_count=0.
  - Reset overrides every other input, including in mid-run.
- States: IDLE, RUN, ZERO (feature only), DONE.
- IDLE:
  - seed_load=1 gives lfsr<=seed. An all-zero seed is replaced by 1 (lock-up avoidance).
  - start=1 gives RUN and pat_count<=0.
  - If start and seed_load are both high, the seed loads and the run starts in the same edge, so the first pattern is the (sanitised) seed.
- RUN:
  - pat_valid=1, busy=1, pat_out=lfsr.
  - Accept when pat_valid&pat_ready at the edge: lfsr<={lfsr[WIDTH-2:0], ^(lfsr&TAPS)} and pat_count++.
  - When the accepted pattern makes pat_count==NUM_PAT, go to DONE (or ZERO when the feature is enabled).
  - If pat_ready=0, pat_out, lfsr and pat_count hold unchanged (stable under backpressure).
  - start and seed_load are ignored in RUN.
- DONE:
  - done=1, pat_valid=0, busy=0 for exactly one cycle, then IDLE.
  - pat_count holds its final value until the next start or reset.
  - lfsr holds its post-run value, so a new start without seed_load continues the sequence.
- Latency:
  - start sampled at edge t gives pat_valid=1 from cycle t+1.
  - Final accept at edge t gives done=1 in cycle t+1 and IDLE at t+2.
- Outputs are registered or decoded from state only; there is no combinational path from pat_ready to pat_valid.
- Sequence for WIDTH=2, TAPS=11, seed 01 is 01, 11, 10, then repeats 01.

Optional Feature:
- Macro: BIST_ALLZERO_EN.
- Defined:
  - After the NUM_PAT-th LFSR accept, the FSM enters ZERO. It presents pat_out=0 with pat_valid=1, busy=1 until accepted.
  - That accept increments pat_count (final value NUM_PAT+1), then DONE. lfsr is unchanged through ZERO.
  - This covers the all-zero vector an LFSR cannot produce.
- Undefined: the ZERO state and its logic are absent; RUN goes directly to DONE and the final pat_count is NUM_PAT.

Test Plan:
- Reset: assert rst 2 cycles -> pat_out=01, pat_valid=0, busy=0, done=0, pat_count=0.
- Full run (defaults): seed_load seed=01, start, pat_ready=1 constantly -> pat_out 01, 11, 10 on 3 consecutive valid cycles; done pulse of 1 cycle; pat_count=3; busy low after.
- Backpressure: start, pat_ready=1 for 1 cycle, then 0 for 4 cycles, then 1 -> pat_out stays 11 with pat_valid=1 for all 4 stall cycles; pat_count stays 1; run completes with pat_count=3.
- Zero seed and ignored controls: seed_load seed=00 -> first pattern 01; pulse start/seed_load (seed=10) mid-RUN -> no effect on sequence or count.
- Reset mid-run: rst after 2 accepts -> next cycle IDLE, pat_valid=0, pat_count=0, pat_out=01, no done pulse.
- BIST_ALLZERO_EN defined: seed 01, pat_ready=1 -> patterns 01, 11, 10, 00; done pulse; pat_count=4.
